// File: rtl/reset_boot_system.sv
// reset_boot_system: boot-time reset sequencer.
// Holds downstream logic in reset for CYCLES clocks after the release of an
// asynchronous active-low reset has crossed a SYNC_STAGES-deep synchronizer,
// and restarts the same hold on a soft request while running.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low block reset
//   soft_reset_req in   synchronous restart request, honoured only in RUN
//   reset_o        out  active-high reset to downstream logic
//   ready          out  complement of reset_o
//   cause          out  last reset source: 00 power-on, 01 external, 10 soft
//   boot_count     out  completed sequences since last external reset, saturating
module reset_boot_system #(
    parameter int unsigned CYCLES      = 20,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       soft_reset_req,
    output logic       reset_o,
    output logic       ready,
    output logic [1:0] cause,
    output logic [7:0] boot_count
);

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned BOOT_W    = 8;
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(CYCLES - 1);
    localparam logic [BOOT_W-1:0] BOOT_MAX = {BOOT_W{1'b1}};

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_EXT  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Power-on values come from register initial values; the external reset
    // differs from them only in cause (01 instead of 00).
    logic [SYNC_STAGES-1:0] sync_q  = '0;
    state_t                 state   = HOLD;
    logic [CNT_W-1:0]       count   = '0;
    logic                   rst_q   = 1'b1;
    logic                   ready_q = 1'b0;
    logic [1:0]             cause_q = CAUSE_POR;
    logic [BOOT_W-1:0]      boot_q  = '0;

    logic released;

    // Reset-release synchronizer: cleared asynchronously, shifts in ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign released = sync_q[SYNC_STAGES-1];

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= HOLD;
            count   <= '0;
            rst_q   <= 1'b1;
            ready_q <= 1'b0;
            cause_q <= CAUSE_EXT;
            boot_q  <= '0;
        end else begin
            case (state)
                HOLD: begin
                    if (released) begin
                        if (count == LAST) begin
                            state   <= RUN;
                            count   <= '0;
                            rst_q   <= 1'b0;
                            ready_q <= 1'b1;
                            if (boot_q != BOOT_MAX) begin
                                boot_q <= boot_q + BOOT_W'(1);
                            end
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (soft_reset_req) begin
                        state   <= HOLD;
                        count   <= '0;
                        rst_q   <= 1'b1;
                        ready_q <= 1'b0;
                        cause_q <= CAUSE_SOFT;
                    end
                end
                default: begin
                    state   <= HOLD;
                    count   <= '0;
                    rst_q   <= 1'b1;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign reset_o    = rst_q;
    assign ready      = ready_q;
    assign cause      = cause_q;
    assign boot_count = boot_q;

endmodule

// File: tb/tb_reset_boot_system.sv
// Testbench for reset_boot_system: three instances with different CYCLES /
// SYNC_STAGES share stimulus; a countdown reference model predicts each
// cycle's outputs into a queue that a negedge monitor pops and compares.
module tb_reset_boot_system;

    localparam int unsigned C0 = 20, S0 = 2;
    localparam int unsigned C1 = 1,  S1 = 2;
    localparam int unsigned C2 = 5,  S2 = 4;
    localparam int N = 3;

    typedef struct packed {
        logic       r;
        logic [1:0] c;
        logic [7:0] b;
    } exp_t;
    typedef exp_t [N-1:0] row_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic soft_reset_req = 1'b0;

    logic       ro [N];
    logic       rd [N];
    logic [1:0] ca [N];
    logic [7:0] bc [N];

    row_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // Reference model: remaining edges until RUN, run flag, cause, boots.
    int m_left  [N];
    bit m_run   [N];
    int m_cause [N];
    int m_boots [N];

    always #5 clk = ~clk;

    reset_boot_system #(.CYCLES(C0), .SYNC_STAGES(S0)) dut0 (
        .clk(clk), .reset(reset), .soft_reset_req(soft_reset_req),
        .reset_o(ro[0]), .ready(rd[0]), .cause(ca[0]), .boot_count(bc[0]));
    reset_boot_system #(.CYCLES(C1), .SYNC_STAGES(S1)) dut1 (
        .clk(clk), .reset(reset), .soft_reset_req(soft_reset_req),
        .reset_o(ro[1]), .ready(rd[1]), .cause(ca[1]), .boot_count(bc[1]));
    reset_boot_system #(.CYCLES(C2), .SYNC_STAGES(S2)) dut2 (
        .clk(clk), .reset(reset), .soft_reset_req(soft_reset_req),
        .reset_o(ro[2]), .ready(rd[2]), .cause(ca[2]), .boot_count(bc[2]));

    function automatic int cyc_of(input int i);
        case (i)
            0: return int'(C0);
            1: return int'(C1);
            default: return int'(C2);
        endcase
    endfunction

    function automatic int sync_of(input int i);
        case (i)
            0: return int'(S0);
            1: return int'(S1);
            default: return int'(S2);
        endcase
    endfunction

    task automatic model_async(input int i);
        m_run[i]   = 1'b0;
        m_left[i]  = sync_of(i) + cyc_of(i);
        m_cause[i] = 1;
        m_boots[i] = 0;
    endtask

    // One rising edge, using the input values the DUT samples at that edge.
    task automatic model_edge(input int i);
        if (!reset) return;
        if (!m_run[i]) begin
            m_left[i]--;
            if (m_left[i] == 0) begin
                m_run[i] = 1'b1;
                if (m_boots[i] < 255) m_boots[i]++;
            end
        end else if (soft_reset_req) begin
            m_run[i]   = 1'b0;
            m_left[i]  = cyc_of(i);
            m_cause[i] = 2;
        end
    endtask

    task automatic push_expected();
        row_t row;
        for (int i = 0; i < N; i++) begin
            row[i].r = !m_run[i];
            row[i].c = 2'(m_cause[i]);
            row[i].b = 8'(m_boots[i]);
        end
        exp_q.push_back(row);
    endtask

    task automatic cycle(input logic r, input logic s);
        @(posedge clk);
        for (int i = 0; i < N; i++) model_edge(i);
        #2;
        reset = r;
        soft_reset_req = s;
        if (!r) for (int i = 0; i < N; i++) model_async(i);
        cyc++;
        push_expected();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0);
    endtask

    // Monitor: compares the head of the expectation queue each sample point.
    task automatic check_row();
        row_t e;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (ro[i] !== e[i].r || rd[i] !== !e[i].r ||
                ca[i] !== e[i].c || bc[i] !== e[i].b) begin
                miscompares++;
                $display("FAIL outputs dut%0d cyc %0d: got reset_o=%b ready=%b cause=%0d boot_count=%0d, want reset_o=%b ready=%b cause=%0d boot_count=%0d",
                         i, cyc, ro[i], rd[i], ca[i], bc[i],
                         e[i].r, !e[i].r, e[i].c, e[i].b);
            end
        end
    endtask

    initial begin
        #1;
        check_row();
        forever begin
            @(negedge clk);
            check_row();
        end
    end

    initial begin
        #2_000_000;
        miscompares++;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hold;
        for (int i = 0; i < N; i++) begin
            m_run[i]   = 1'b0;
            m_left[i]  = sync_of(i) + cyc_of(i);
            m_cause[i] = 0;
            m_boots[i] = 0;
        end
        push_expected();

        // Power-on boot with reset held high.
        idle(30);
        // Single-cycle soft request while running.
        cycle(1'b1, 1'b1);
        idle(30);
        // External reset for 3 cycles.
        repeat (3) cycle(1'b0, 1'b0);
        idle(30);
        // External reset mid-HOLD (counter around 10 for the long instance).
        idle(0);
        repeat (2) cycle(1'b0, 1'b0);
        idle(12);
        repeat (2) cycle(1'b0, 1'b0);
        idle(30);
        // Reset and soft request together while running.
        cycle(1'b0, 1'b1);
        idle(30);

        // Randomized soft requests and occasional external resets.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                hold = int'($urandom_range(1, 3));
                for (int k = 0; k < hold; k++)
                    cycle(1'b0, 1'($urandom_range(0, 1)));
            end else begin
                cycle(1'b1, ($urandom_range(0, 7) == 0));
            end
        end

        // Continuous soft request: 300+ sequences, boot_count saturates.
        repeat (2) cycle(1'b0, 1'b0);
        for (int n = 0; n < 300 * (int'(C0) + 1) + 100; n++) cycle(1'b1, 1'b1);
        idle(30);

        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reset_boot_system.md
RESET_BOOT_SYSTEM -- requirements
Module: reset_boot_system

Interface
REQ-001 The block SHALL have parameter CYCLES, default 20, the number of clock cycles the reset output is held after release; legal range 1..65535.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, the depth of the reset-release synchronizer; legal range 2..4.
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge except asynchronous reset.
REQ-004 Port reset  input  1  asynchronous, active-low block reset.
REQ-005 Port soft_reset_req  input  1  synchronous request to restart the boot-reset sequence; sampled on rising edges.
REQ-006 Port reset_o  output  1  active-high reset for downstream logic (core, controller).
REQ-007 Port ready  output  1  high when downstream logic is out of reset.
REQ-008 Port cause  output  2  last reset source: 00 power-on, 01 external reset, 10 soft request, 11 unused.
REQ-009 Port boot_count  output  8  number of completed reset sequences, saturating.

Function
REQ-010 The block SHALL implement two states: HOLD (reset_o=1, ready=0) and RUN (reset_o=0, ready=1); all outputs SHALL be registered.
REQ-011 Power-on (register initial values) SHALL equal: state HOLD, counter 0, reset_o=1, ready=0, cause=00, boot_count=0, synchronizer all 0; the block SHALL complete a boot sequence with reset held high throughout.
REQ-012 While reset=0, reset_o SHALL be 1 and ready 0 immediately (no clock needed), the counter and synchronizer cleared, and the state forced to HOLD.
REQ-013 Reset release SHALL pass through a SYNC_STAGES-deep flip-flop chain (asynchronously cleared by reset, shifting in 1); counting in HOLD SHALL occur only when the chain output is 1.
REQ-014 In HOLD, with the chain output at 1, the counter SHALL increment by 1 each rising edge; on the edge where counter equals CYCLES-1, the state SHALL become RUN, reset_o 0, ready 1, and the counter SHALL clear.
REQ-015 After reset deassertion (set up before the next edge), reset_o SHALL fall on exactly the (SYNC_STAGES+CYCLES)th rising edge.
REQ-016 In RUN, soft_reset_req=1 at a rising edge SHALL move the state to HOLD, set reset_o=1, ready=0, cause=10, and clear the counter; reset_o SHALL fall again on the (CYCLES+1)th edge counted from that edge inclusive.
REQ-017 soft_reset_req SHALL be ignored in HOLD; a request held high continuously SHALL restart the sequence once per RUN entry (one RUN cycle between sequences).
REQ-018 Each HOLD-to-RUN transition SHALL increment boot_count by 1, saturating at 255.
REQ-019 The counter SHALL be 16 bits wide; counting SHALL never wrap within a sequence.
REQ-020 reset asserted mid-sequence (HOLD or RUN, including the same edge as soft_reset_req) SHALL take priority and restart the sequence from REQ-012.

Reset
REQ-021 On reset=0 the block SHALL asynchronously set reset_o=1, ready=0, cause=01, boot_count=0, counter 0, synchronizer 0, state HOLD.
REQ-022 ready SHALL always equal the complement of reset_o, including during asynchronous reset.

Verification
REQ-023 Power-on, reset held 1, CYCLES=20, SYNC_STAGES=2 -> reset_o falls on edge 20 after the first synchronizer 1 reaches output (edge 22 total), cause=00, boot_count=1.
REQ-024 Drive reset=0 for 3 cycles then 1 -> reset_o=1 immediately on assertion, falls on the 22nd edge after release, cause=01, boot_count=1.
REQ-025 In RUN pulse soft_reset_req one cycle -> reset_o=1 after that edge for 21 edges total, cause=10, boot_count increments by 1.
REQ-026 Assert reset=0 while counter=10 in HOLD -> reset_o stays 1, counter returns to 0, full 22-edge sequence repeats after release.
REQ-027 Hold soft_reset_req=1 for 300 sequences -> boot_count saturates at 255, one RUN cycle between consecutive HOLD periods.
REQ-028 CYCLES=1, SYNC_STAGES=2 -> reset_o falls on the 3rd edge after release.
